instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue: FSM state,
// queue entry layout, and the default depth / reset PC.
package fetch_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned  DEFAULT_DEPTH    = 4;
    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store for fetched instructions. The head is visible
// combinationally; flush empties the queue and wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t entries_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) entries_q[wr_ptr_q] <= push_entry;
    end

    assign head_valid = (count_q != '0);
    assign head_entry = entries_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// small queue, with redirect handling and a DRAIN state for in-flight reads.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = fetch_pkg::DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_rdata,
    input  logic                         if_ready,
    output logic                         if_valid,
    output logic [31:0]                  if_pc,
    output logic [31:0]                  if_pc4,
    output logic [31:0]                  if_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e state_q, state_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;

    logic         ack_take, push, pop, flush, has_space, issue;
    logic         head_valid;
    fetch_entry_t push_entry, head_entry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (redirect_valid && req_q && !imem_ack) state_d = ST_DRAIN;
            ST_DRAIN: if (imem_ack) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ack_take  = req_q & imem_ack;
        flush     = redirect_valid;
        pop       = head_valid & if_ready & ~redirect_valid;
        push      = (state_q == ST_RUN) & ack_take & ~redirect_valid;
        // an outstanding request always has a slot reserved, so no push can overflow
        has_space = (count < CW'(DEPTH)) | pop;
        issue     = (state_q == ST_RUN) & ~req_q & (has_space | redirect_valid);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        if (redirect_valid)
            fetch_pc_d = redirect_pc;
        else if (push)
            fetch_pc_d = fetch_pc_q + 32'd4;
        if (ack_take) begin
            req_d = 1'b0;
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .count      (count)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = head_valid;
    assign if_pc     = head_valid ? head_entry.pc          : 32'd0;
    assign if_pc4    = head_valid ? head_entry.pc + 32'd4  : 32'd0;
    assign if_instr  = head_valid ? head_entry.instr       : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a cycle table for streaming fetch
// plus hand sequences for stall, redirect, drain and reset corner cases.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    bit auto_mem = 1'b1;
    int mem_wait = 0;

    instr_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_ready       (if_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_instr       (if_instr),
        .count          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        int          e_cnt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory with one cycle of latency: ack arrives in the second cycle of a request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (imem_ack) begin
                imem_ack   = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                mem_wait   = 0;
            end else if (imem_req) begin
                if (mem_wait >= 1) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(imem_addr);
                end else begin
                    mem_wait++;
                end
            end
        end
    endtask

    task automatic check_state(input string name, input logic e_req, input logic [31:0] e_addr,
                               input int e_cnt, input logic [31:0] e_pc);
        logic e_valid;
        e_valid = (e_cnt != 0);
        check({name, ".req"},   {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) check({name, ".addr"}, imem_addr, e_addr);
        check({name, ".count"}, {29'd0, count}, e_cnt);
        check({name, ".valid"}, {31'd0, if_valid}, {31'd0, e_valid});
        check({name, ".pc"},    if_pc,    e_valid ? e_pc : 32'd0);
        check({name, ".pc4"},   if_pc4,   e_valid ? e_pc + 32'd4 : 32'd0);
        check({name, ".instr"}, if_instr, e_valid ? word_of(e_pc) : 32'd0);
        $display("%s: req=%0b addr=%h count=%0d valid=%0b pc=%h", name, imem_req, imem_addr,
                 count, if_valid, if_pc);
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if_ready       = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        auto_mem       = 1'b1;
        mem_wait       = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state("rst", 1'b0, 32'd0, 0, 32'd0);
        check("rst.addr", imem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // streaming fetch, cycles 1..9 after reset release
        vecs[0] = '{1'b1, 1'b1, 32'h0, 0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0, 0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h4, 0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 32'h4, 0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h4, 1, 32'h4};
        vecs[6] = '{1'b1, 1'b1, 32'h8, 0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h8, 0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h8, 1, 32'h8};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if_ready = vecs[i].rdy;
            tick();
            check_state($sformatf("stream%0d", i), vecs[i].e_req, vecs[i].e_addr,
                        vecs[i].e_cnt, vecs[i].e_pc);
        end

        // stall: queue fills to DEPTH, requests stop, head stays at 0x0
        do_reset();
        if_ready = 1'b0;
        repeat (14) tick();
        check_state("full", 1'b0, 32'd0, 4, 32'h0);
        if_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("drain_order%0d.valid", i), {31'd0, if_valid}, 32'd1);
            check($sformatf("drain_order%0d.pc", i), if_pc, 32'(4 * i));
            $display("pop%0d: pc=%h count=%0d", i, if_pc, count);
            tick();
        end

        // redirect with request to 0x8 outstanding, late ack
        do_reset();
        if_ready = 1'b1;
        repeat (7) tick();
        check_state("pre_redir", 1'b1, 32'h8, 0, 32'h0);
        auto_mem       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check_state("drain_hold", 1'b1, 32'h8, 0, 32'h0);
        repeat (2) tick();
        check_state("drain_hold2", 1'b1, 32'h8, 0, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = word_of(32'h8);
        tick();
        imem_ack   = 1'b0;
        check_state("drain_ack", 1'b0, 32'h0, 0, 32'h0);
        auto_mem = 1'b1;
        mem_wait = 0;
        tick();
        check_state("redir_req", 1'b1, 32'h40, 0, 32'h0);
        repeat (2) tick();
        check_state("redir_data", 1'b0, 32'h0, 1, 32'h40);

        // redirect in the same cycle as the ack
        do_reset();
        if_ready = 1'b1;
        repeat (2) tick();
        check("coinc.ack", {31'd0, imem_ack}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check_state("coinc_drop", 1'b0, 32'h0, 0, 32'h0);
        tick();
        check_state("coinc_req", 1'b1, 32'h100, 0, 32'h0);
        repeat (2) tick();
        check_state("coinc_data", 1'b0, 32'h0, 1, 32'h100);

        // second redirect during DRAIN wins
        do_reset();
        if_ready = 1'b1;
        tick();
        auto_mem       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        check_state("dd_first", 1'b1, 32'h0, 0, 32'h0);
        redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check_state("dd_second", 1'b1, 32'h0, 0, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = word_of(32'h0);
        tick();
        imem_ack   = 1'b0;
        check_state("dd_ack", 1'b0, 32'h0, 0, 32'h0);
        auto_mem = 1'b1;
        mem_wait = 0;
        tick();
        check_state("dd_req", 1'b1, 32'h80, 0, 32'h0);
        repeat (2) tick();
        check_state("dd_data", 1'b0, 32'h0, 1, 32'h80);

        // reset asserted mid-request with an entry queued
        do_reset();
        if_ready = 1'b0;
        repeat (4) tick();
        check_state("pre_rst", 1'b1, 32'h4, 1, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_state("async_rst", 1'b0, 32'h0, 0, 32'h0);
        check("async_rst.addr", imem_addr, 32'd0);
        imem_ack = 1'b0;
        mem_wait = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_state("post_rst", 1'b1, 32'h0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
